// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32M opcode constants and the muldiv sequencer state type.
package rv_pkg;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;
    typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: one shift-add / restoring-divide step on a {hi,lo} accumulator plus sign fix-up of the stepped value.
module muldiv_datapath
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   m,
    input  logic              sa,
    input  logic              sb,
    output logic [2*XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0]   result
);
    logic [XLEN:0]     sum, shl, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    // Divide keeps remainder in hi and shifts quotient bits into lo; diff[XLEN] is the borrow.
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, m};
        shl     = acc[2*XLEN-1:XLEN-1];
        diff    = shl - {1'b0, m};
        acc_nxt = funct3[2] ? (diff[XLEN] ? {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                          : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                            : (acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]});
        prod    = (sa ^ sb) ? -acc_nxt : acc_nxt;
        quo     = (sa ^ sb) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem     = sa ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        result  = funct3[2] ? (funct3[1] ? rem : quo)
                            : (funct3 == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide FSM with valid/ready handshakes and pipeline stall.
module muldiv_sequencer
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            stall_o
);
    muldiv_state_t     state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3;
    logic              sa, sb, in_sa, in_sb, dz, ovf;
    logic [XLEN-1:0]   m, a_abs, b_abs, spec_res, fix_res;
    logic [2*XLEN-1:0] acc, acc_nxt;
    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .funct3  (f3),
        .acc     (acc),
        .m       (m),
        .sa      (sa),
        .sb      (sb),
        .acc_nxt (acc_nxt),
        .result  (fix_res)
    );
    // Operand signedness: MUL/MULH both signed, MULHSU rs1 only, DIV/REM both, U ops neither.
    always_comb begin
        in_sa    = rs1_i[XLEN-1] && (funct3_i[2] ? !funct3_i[0] : funct3_i != MULHU);
        in_sb    = rs2_i[XLEN-1] && (funct3_i[2] ? !funct3_i[0] : !funct3_i[1]);
        a_abs    = in_sa ? -rs1_i : rs1_i;
        b_abs    = in_sb ? -rs2_i : rs2_i;
        dz       = funct3_i[2] && rs2_i == '0;
        ovf      = funct3_i[2] && !funct3_i[0] && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_i == '1;
        spec_res = dz ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);
        stall_o  = (state != IDLE) || (valid_i && state == IDLE);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            f3       <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            m        <= '0;
            acc      <= '0;
            result_o <= '0;
            valid_o  <= 1'b0;
            ready_o  <= 1'b1;
        end else if (flush_i) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            case (state)
                IDLE: if (valid_i && ready_o) begin
                    f3      <= funct3_i;
                    sa      <= in_sa;
                    sb      <= in_sb;
                    cnt     <= '0;
                    ready_o <= 1'b0;
                    m       <= funct3_i[2] ? b_abs : a_abs;
                    acc     <= {{XLEN{1'b0}}, funct3_i[2] ? a_abs : b_abs};
                    if (dz || ovf) begin
                        state    <= DONE;
                        result_o <= spec_res;
                        valid_o  <= 1'b1;
                    end else begin
                        state <= CALC;
                    end
                end
                // The last iteration's fix-up is registered with it, so accept-to-valid is XLEN+1 edges.
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        state    <= DONE;
                        result_o <= fix_res;
                        valid_o  <= 1'b1;
                    end
                end
                DONE: if (ready_i) begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven RV32M vectors plus backpressure, flush and mid-op reset sequences.
module tb_muldiv_sequencer;
    logic        clk, rst_n, valid_i, ready_o, flush_i, valid_o, ready_i, stall_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i, result_o;
    int          n_pass, n_total;
    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[18];
    muldiv_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .stall_o  (stall_o)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Issues one request and waits for valid_o; lat counts edges from the accept edge inclusive.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic stall_ok);
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        valid_i  = 1'b1;
        #1;
        stall_ok = stall_o;
        tick();
        valid_i = 1'b0;
        lat     = 1;
        while (!valid_o && lat < 100) begin
            stall_ok &= stall_o;
            tick();
            lat++;
        end
        stall_ok &= stall_o;
    endtask
    task automatic run_vec(input int i, input vec_t v);
        int   lat;
        logic st;
        issue(v.f3, v.a, v.b, lat, st);
        chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d result", i), result_o, v.exp);
        chk($sformatf("v%0d stall", i), {31'b0, st}, 32'd1);
        tick();
        chk($sformatf("v%0d release", i), {30'b0, valid_o, ready_o}, 32'd1);
    endtask
    initial begin
        int          lat;
        logic        st, seen;
        logic [31:0] held;
        n_pass  = 0;
        n_total = 0;
        vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 33};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'b100, 32'd123,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[13] = '{3'b101, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 33};
        vecs[14] = '{3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[15] = '{3'b111, 32'd9,         32'd0,         32'd9,         1};
        vecs[16] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[17] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        funct3_i = '0; rs1_i = '0; rs2_i = '0;
        tick();
        tick();
        chk("reset ready_o", {31'b0, ready_o}, 32'd1);
        chk("reset valid_o", {31'b0, valid_o}, 32'd0);
        chk("reset stall_o", {31'b0, stall_o}, 32'd0);
        chk("reset result_o", result_o, 32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);
        // Backpressure: hold the result for 10 cycles in DONE.
        ready_i = 1'b0;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, lat, st);
        chk("bp latency", 32'(lat), 32'd33);
        held = result_o;
        for (int k = 0; k < 10; k++) begin
            tick();
            st &= valid_o & stall_o & !ready_o & (result_o == held);
        end
        chk("bp hold", {31'b0, st}, 32'd1);
        chk("bp result", result_o, 32'hFFFF_FFEB);
        ready_i = 1'b1;
        tick();
        chk("bp release", {30'b0, valid_o, ready_o}, 32'd1);
        // Flush during iteration 12.
        funct3_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd5; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush idle", {29'b0, valid_o, ready_o, stall_o}, 32'b010);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            seen |= valid_o;
        end
        chk("flush no valid", {31'b0, seen}, 32'd0);
        // Flush and request together in IDLE: nothing is accepted.
        funct3_i = 3'b100; rs1_i = 32'd9; rs2_i = 32'd0; valid_i = 1'b1; flush_i = 1'b1;
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        tick();
        chk("flush wins", {30'b0, valid_o, ready_o}, 32'd1);
        // Reset mid-CALC, then a fresh request must complete.
        funct3_i = 3'b101; rs1_i = 32'd50; rs2_i = 32'd4; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        tick();
        chk("rst mid ctl", {29'b0, valid_o, ready_o, stall_o}, 32'b010);
        chk("rst mid result", result_o, 32'd0);
        rst_n = 1'b1;
        tick();
        run_vec(100, '{3'b111, 32'd50, 32'd4, 32'd2, 33});
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
